// File: rtl/fc_pkg.sv
// Shared types and constants for the FC buffer loader.
package fc_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StLoadIfmap,
    StLoadWeight,
    StStart,
    StWaitFc
  } fc_ld_state_e;

  localparam logic [8:0]  MAX_IN_NODE    = 9'd128;
  localparam logic [6:0]  MAX_OUT_NODE   = 7'd84;
  localparam logic [13:0] MAX_WBUF_BYTES = 14'd10752;

  // A layer is loadable only when both node counts are non-zero and within the FC limits.
  function automatic logic cfg_ok(logic [8:0] in_n, logic [6:0] out_n);
    return (in_n != 9'd0) && (in_n <= MAX_IN_NODE) &&
           (out_n != 7'd0) && (out_n <= MAX_OUT_NODE);
  endfunction

  // Index of the final weight byte (in*out - 1); the product never exceeds 14 bits.
  function automatic logic [13:0] w_last_idx(logic [8:0] in_n, logic [6:0] out_n);
    return 14'(in_n) * 14'(out_n) - 14'd1;
  endfunction

endpackage

// File: rtl/fc_wr_port.sv
// Registered write stage: strobe, pointer and data appear one cycle after the request.
module fc_wr_port #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          wren_o,
  output logic [AW-1:0] wrptr_o,
  output logic [DW-1:0] wdata_o
);

  logic          wren_q;
  logic [AW-1:0] wrptr_q;
  logic [DW-1:0] wdata_q;

  // Strobe follows the request every cycle; pointer and data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q  <= 1'b0;
      wrptr_q <= '0;
      wdata_q <= '0;
    end else begin
      wren_q <= we_i;
      if (we_i) begin
        wrptr_q <= addr_i;
        wdata_q <= data_i;
      end
    end
  end

  assign wren_o  = wren_q;
  assign wrptr_o = wrptr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/fc_buf_loader.sv
// Streams one layer's ifmap then weight bytes into the FC buffers, kicks the FC engine
// and reports completion when its last result beat is seen.
module fc_buf_loader
  import fc_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned IFMAP_AW = 10,
  parameter int unsigned WBUF_AW  = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start_i,
  input  logic [8:0]          in_node_num_i,
  input  logic [6:0]          out_node_num_i,
  input  logic [1:0]          nth_fully_i,
  input  logic                s_valid_i,
  input  logic [DW-1:0]       s_data_i,
  input  logic                s_last_i,
  output logic                s_ready_o,
  output logic                ifmap_wren_o,
  output logic [IFMAP_AW-1:0] ifmap_wrptr_o,
  output logic [DW-1:0]       ifmap_wdata_o,
  output logic                wbuf_wren_o,
  output logic [WBUF_AW-1:0]  wbuf_wrptr_o,
  output logic [DW-1:0]       wbuf_wdata_o,
  output logic                fc_start_o,
  output logic [8:0]          in_node_num_o,
  output logic [6:0]          out_node_num_o,
  output logic [1:0]          nth_fully_o,
  input  logic                fc_valid_i,
  input  logic                fc_last_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  fc_ld_state_e state_q, state_d;
  logic [8:0]   ifmap_cnt_q, ifmap_cnt_d;
  logic [13:0]  wgt_cnt_q, wgt_cnt_d;
  logic [13:0]  w_last_q, w_last_d;
  logic [8:0]   in_node_q, in_node_d;
  logic [6:0]   out_node_q, out_node_d;
  logic [1:0]   nth_q, nth_d;
  logic         err_q, err_d;
  logic         done_q, done_d;
  logic         fc_start_q, fc_start_d;

  logic         s_ready;
  logic         ifmap_we;
  logic         wbuf_we;

  // State, counters and latched configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ifmap_cnt_q <= '0;
      wgt_cnt_q   <= '0;
      w_last_q    <= '0;
      in_node_q   <= '0;
      out_node_q  <= '0;
      nth_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      fc_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ifmap_cnt_q <= ifmap_cnt_d;
      wgt_cnt_q   <= wgt_cnt_d;
      w_last_q    <= w_last_d;
      in_node_q   <= in_node_d;
      out_node_q  <= out_node_d;
      nth_q       <= nth_d;
      err_q       <= err_d;
      done_q      <= done_d;
      fc_start_q  <= fc_start_d;
    end
  end

  // Next-state logic, stream acceptance and s_last protocol checking.
  always_comb begin
    state_d     = state_q;
    ifmap_cnt_d = ifmap_cnt_q;
    wgt_cnt_d   = wgt_cnt_q;
    w_last_d    = w_last_q;
    in_node_d   = in_node_q;
    out_node_d  = out_node_q;
    nth_d       = nth_q;
    err_d       = err_q;
    done_d      = 1'b0;
    fc_start_d  = 1'b0;
    s_ready     = 1'b0;
    ifmap_we    = 1'b0;
    wbuf_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_start_i) begin
          if (cfg_ok(in_node_num_i, out_node_num_i)) begin
            in_node_d   = in_node_num_i;
            out_node_d  = out_node_num_i;
            nth_d       = nth_fully_i;
            w_last_d    = w_last_idx(in_node_num_i, out_node_num_i);
            ifmap_cnt_d = '0;
            wgt_cnt_d   = '0;
            err_d       = 1'b0;
            state_d     = StLoadIfmap;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StLoadIfmap: begin
        s_ready = 1'b1;
        if (s_valid_i) begin
          ifmap_we = 1'b1;
          if (s_last_i) begin
            // Last can never legally fall on an ifmap byte: abandon the layer.
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (ifmap_cnt_q == in_node_q - 9'd1) begin
            ifmap_cnt_d = '0;
            state_d     = StLoadWeight;
          end else begin
            ifmap_cnt_d = ifmap_cnt_q + 9'd1;
          end
        end
      end

      StLoadWeight: begin
        s_ready = 1'b1;
        if (s_valid_i) begin
          wbuf_we = 1'b1;
          if (wgt_cnt_q == w_last_q) begin
            // A missing last on the final byte is flagged but the layer still runs.
            if (!s_last_i) begin
              err_d = 1'b1;
            end
            state_d = StStart;
          end else if (s_last_i) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            wgt_cnt_d = wgt_cnt_q + 14'd1;
          end
        end
      end

      StStart: begin
        // Registered so the pulse lands the cycle after the final weight strobe.
        fc_start_d = 1'b1;
        state_d    = StWaitFc;
      end

      StWaitFc: begin
        if (fc_valid_i && fc_last_i) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  fc_wr_port #(
    .AW (IFMAP_AW),
    .DW (DW)
  ) u_ifmap_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ifmap_we),
    .addr_i  (IFMAP_AW'(ifmap_cnt_q)),
    .data_i  (s_data_i),
    .wren_o  (ifmap_wren_o),
    .wrptr_o (ifmap_wrptr_o),
    .wdata_o (ifmap_wdata_o)
  );

  fc_wr_port #(
    .AW (WBUF_AW),
    .DW (DW)
  ) u_wbuf_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wbuf_we),
    .addr_i  (WBUF_AW'(wgt_cnt_q)),
    .data_i  (s_data_i),
    .wren_o  (wbuf_wren_o),
    .wrptr_o (wbuf_wrptr_o),
    .wdata_o (wbuf_wdata_o)
  );

  assign s_ready_o      = s_ready;
  assign fc_start_o     = fc_start_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q != StIdle);
  assign in_node_num_o  = in_node_q;
  assign out_node_num_o = out_node_q;
  assign nth_fully_o    = nth_q;

endmodule

// File: doc/fc_buf_loader.md
Name: fc_buf_loader

Overview:
- Producer side of the fully-connected block's buffer write ports. Consumes one byte stream (valid/ready) from the DMA/layer sequencer.
- Writes the ifmap bytes, then the weight bytes, into the FC buffers. Pulses the FC start, then waits for the FC result stream's last beat and reports done.
- Sits between the layer sequencer and the FC top, one instance per FC engine.

Parameters:
- DW, 8, data byte width
- IFMAP_AW, 10, ifmap buffer write-pointer width
- WBUF_AW, 17, weight buffer write-pointer width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start_i  in  1  one-cycle request to begin a layer load; ignored unless IDLE
- in_node_num_i  in  9  input nodes, 1..128; sampled on accepted cfg_start_i
- out_node_num_i  in  7  output nodes, 1..84; sampled on accepted cfg_start_i
- nth_fully_i  in  2  layer index; sampled on accepted cfg_start_i
- s_valid_i  in  1  stream byte valid
- s_data_i  in  DW  stream byte
- s_last_i  in  1  marks final byte of the layer (last weight byte)
- s_ready_o  out  1  loader accepts byte
- ifmap_wren_o  out  1  ifmap buffer write strobe
- ifmap_wrptr_o  out  IFMAP_AW  ifmap write address
- ifmap_wdata_o  out  DW  ifmap write data
- wbuf_wren_o  out  1  weight buffer write strobe
- wbuf_wrptr_o  out  WBUF_AW  weight write address
- wbuf_wdata_o  out  DW  weight write data
- fc_start_o  out  1  one-cycle FC start pulse
- in_node_num_o  out  9  latched in_node_num to FC
- out_node_num_o  out  7  latched out_node_num to FC
- nth_fully_o  out  2  latched layer index to FC
- fc_valid_i  in  1  FC result valid, observed only
- fc_last_i  in  1  FC last result, observed only
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse when the layer completes
- err_o  out  1  sticky protocol error; cleared by the next accepted cfg_start_i

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All strobes, pulses, busy_o and err_o go to 0. Pointers, data and latched config go to 0.
  - Reset mid-load abandons the layer with no done_o.
- State IDLE:
  - s_ready_o=0.
  - On cfg_start_i with in_node_num_i in 1..128 and out_node_num_i in 1..84: latch config, clear err_o, compute W_TOTAL = in*out (max 10752), go to LOAD_IFMAP.
  - Out-of-range config: set err_o, stay IDLE.
- State LOAD_IFMAP:
  - s_ready_o=1. Each handshake (s_valid_i & s_ready_o) writes the byte at ifmap index k = 0..in-1.
  - After byte in-1, go to LOAD_WEIGHT.
- State LOAD_WEIGHT:
  - s_ready_o=1. Handshake j writes weight byte at linear address j = 0..W_TOTAL-1 (output-node-major: j = o*in + i).
  - After byte W_TOTAL-1, go to START.
- Write port timing: registered. A handshake in cycle N gives wren=1 with pointer and data in cycle N+1. Back-to-back handshakes give back-to-back writes. No write occurs without a handshake.
- s_last_i checks:
  - s_last_i must be 1 exactly on weight byte W_TOTAL-1.
  - Early s_last_i (on any ifmap byte or earlier weight byte): set err_o, go to IDLE. The offending byte is still written.
  - Missing s_last_i on the final byte: set err_o, but proceed normally.
- State START: fc_start_o=1 for exactly one cycle, which is the cycle after the final weight write strobe. Go to WAIT_FC.
- State WAIT_FC:
  - s_ready_o=0.
  - On fc_valid_i & fc_last_i: go to IDLE and pulse done_o for one cycle (the next cycle). busy_o falls in that same cycle.
  - fc_valid_i without fc_last_i is ignored.
- Latched config outputs hold from acceptance until the next accepted cfg_start_i.
- Counters: index counters are internal, 9 bits for ifmap and 14 bits for weights, zero-extended onto the pointer widths. Comparisons are against in-1 and W_TOTAL-1, so no wrap-around occurs.
- Simultaneous events:
  - cfg_start_i while busy is ignored.
  - A stream beat in IDLE/START/WAIT_FC is not accepted, because ready is 0.

Decomposition:
- Package fc_pkg:
  - typedef enum of the loader states {IDLE, LOAD_IFMAP, LOAD_WEIGHT, START, WAIT_FC}
  - constants MAX_IN_NODE=128, MAX_OUT_NODE=84, MAX_WBUF_BYTES=10752
- Optional sub-module fc_wr_port: a registered strobe/pointer/data stage, instantiated twice (ifmap and weight).

Test Plan:
- Config in=4, out=2, continuous stream 0x01..0x0C with s_last_i on byte 12:
  - ifmap writes at ptr 0..3 with data 01..04.
  - wbuf writes at ptr 0..7 with data 05..0C.
  - fc_start_o one cycle after the wbuf ptr-7 write.
  - After fc_valid_i & fc_last_i, done_o pulses once.
- Same config with s_valid_i toggled every other cycle: identical pointer and data sequence, with no duplicate or missing writes.
- Config in=128, out=84: exactly 128 ifmap writes and 10752 wbuf writes, with the final wbuf_wrptr_o=10751; then fc_start_o.
- Config in=0 or out=85: err_o=1, busy_o stays 0, s_ready_o stays 0. A following valid config clears err_o.
- Config in=4, out=2 with s_last_i on byte 6: byte 6 is written to wbuf ptr 1, then err_o=1, state IDLE, and no fc_start_o.
- rst_n low after 3 weight beats: all outputs 0 immediately. After release, a new full load runs with pointers starting from 0.
